fp32_to_int32: RTL and testbench

Multi-cycle converter from an IEEE-754 single-precision value to a signed 32-bit two's-complement integer. It performs the inverse of the array's float-packing path: it de-normalizes the 24-bit significand with an iterative one-bit-per-cycle shifter, optionally rounds, applies the sign and saturates out-of-range inputs. It sits on the result drain of the systolic array, feeding integer-consuming logic through valid/ready handshakes on both sides.

---
 rtl/fp32_to_int32.sv | 170 +++++++++++++++++
 tb/tb_fp32_to_int32.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32.sv
// FP32 -> INT32 converter: iterative one-bit-per-cycle de-normalizer with saturation.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default build truncates toward zero.
module fp32_to_int32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out,
    output logic        isZero,
    output logic        ovf,
    output logic        inexact
);

    typedef enum logic [1:0] {IDLE, SHIFT, FINISH, DONE} state_t;

    state_t      state;
    logic        sign_q;
    logic        left_q;
    logic        guard_q;
    logic        sticky_q;
    logic        spec_q;
    logic        spec_ovf_q;
    logic        spec_inx_q;
    logic [31:0] spec_res_q;
    logic [31:0] mag_q;
    logic [4:0]  cnt_q;

    logic               acc_spec;
    logic               acc_sovf;
    logic               acc_sinx;
    logic [31:0]        acc_res;
    logic [31:0]        acc_mag;
    logic               acc_guard;
    logic               acc_sticky;
    logic               acc_left;
    logic [4:0]         acc_n;
    logic signed [9:0]  acc_e;

    // Operand classification, evaluated on the accept cycle.
    always_comb begin
        acc_e      = $signed({2'b00, A[30:23]}) - 10'sd127;
        acc_spec   = 1'b0;
        acc_sovf   = 1'b0;
        acc_sinx   = 1'b0;
        acc_res    = '0;
        acc_mag    = {8'b0, 1'b1, A[22:0]};
        acc_guard  = 1'b0;
        acc_sticky = 1'b0;
        acc_left   = 1'b0;
        acc_n      = '0;
        if (A[30:23] == 8'd0) begin
            acc_spec = 1'b1;
            acc_sinx = |A[22:0];
        end else if (A[30:23] == 8'hFF) begin
            acc_spec = 1'b1;
            acc_res  = 32'h7FFF_FFFF;
            acc_sovf = 1'b1;
        end else if (acc_e >= 10'sd31) begin
            acc_spec = 1'b1;
            if (A == 32'hCF00_0000) begin
                acc_res = 32'h8000_0000;
            end else begin
                acc_res  = A[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                acc_sovf = 1'b1;
            end
        end else if (acc_e < 10'sd0) begin
            // Fold sub-unity values into guard/sticky so FINISH rounds them like any right shift:
            // E == -1 puts the 0.5 bit in guard and the fraction in sticky.
            acc_mag    = '0;
            acc_guard  = (acc_e == -10'sd1);
            acc_sticky = (acc_e == -10'sd1) ? |A[22:0] : 1'b1;
        end else if (acc_e >= 10'sd23) begin
            acc_left = 1'b1;
            acc_n    = 5'(acc_e - 10'sd23);
        end else begin
            acc_n    = 5'(10'sd23 - acc_e);
        end
    end

    logic [31:0] fin_mag;
    logic [31:0] fin_out;

    always_comb begin
        fin_mag = mag_q;
`ifdef FP2INT_ROUND_NEAREST_EN
        fin_mag = mag_q + {31'b0, guard_q & (sticky_q | mag_q[0])};
`endif
        fin_out = sign_q ? (~fin_mag + 32'd1) : fin_mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            Out        <= '0;
            isZero     <= 1'b1;
            ovf        <= 1'b0;
            inexact    <= 1'b0;
            sign_q     <= 1'b0;
            left_q     <= 1'b0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            spec_q     <= 1'b0;
            spec_ovf_q <= 1'b0;
            spec_inx_q <= 1'b0;
            spec_res_q <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_q     <= A[31];
                        left_q     <= acc_left;
                        guard_q    <= acc_guard;
                        sticky_q   <= acc_sticky;
                        spec_q     <= acc_spec;
                        spec_ovf_q <= acc_sovf;
                        spec_inx_q <= acc_sinx;
                        spec_res_q <= acc_res;
                        mag_q      <= acc_mag;
                        cnt_q      <= acc_n;
                        in_ready   <= 1'b0;
                        state      <= (!acc_spec && acc_n != 5'd0) ? SHIFT : FINISH;
                    end
                end
                SHIFT: begin
                    if (left_q) begin
                        mag_q <= mag_q << 1;
                    end else begin
                        sticky_q <= sticky_q | guard_q;
                        guard_q  <= mag_q[0];
                        mag_q    <= mag_q >> 1;
                    end
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd1)
                        state <= FINISH;
                end
                FINISH: begin
                    if (spec_q) begin
                        Out     <= spec_res_q;
                        isZero  <= (spec_res_q == 32'd0);
                        ovf     <= spec_ovf_q;
                        inexact <= spec_inx_q;
                    end else begin
                        Out     <= fin_out;
                        isZero  <= (fin_out == 32'd0);
                        ovf     <= 1'b0;
                        inexact <= guard_q | sticky_q;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int32.sv
// Self-checking bench for fp32_to_int32: directed corner cases, randomized operands against
// an arithmetic reference model, backpressure, reset mid-operation and streaming.
module tb_fp32_to_int32;

`ifdef FP2INT_ROUND_NEAREST_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Out;
    logic        isZero;
    logic        ovf;
    logic        inexact;

    int checks = 0;
    int miscompares = 0;

    fp32_to_int32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .isZero    (isZero),
        .ovf       (ovf),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    // Value-level model: significand times a power of two, then range check.
    task automatic ref_model(input logic [31:0] a, output logic [31:0] o, output logic ov,
                             output logic ix, output int lat);
        int     e;
        int     sh;
        longint sig, mag, ip, rem, half;
        logic   up;
        e   = int'(a[30:23]) - 127;
        sig = longint'({1'b1, a[22:0]});
        ov  = 1'b0;
        ix  = 1'b0;
        lat = 2;
        o   = 32'd0;
        if (a[30:23] == 8'd0) begin
            ix = (a[22:0] != 23'd0);
        end else if (a[30:23] == 8'hFF) begin
            o  = 32'h7FFF_FFFF;
            ov = 1'b1;
        end else begin
            if (e >= 40) begin
                mag = 64'h1_0000_0000;
            end else if (e >= 23) begin
                mag = sig << (e - 23);
            end else begin
                sh = 23 - e;
                if (sh <= 24) begin
                    ip   = sig >> sh;
                    rem  = sig - (ip << sh);
                    half = longint'(1) << (sh - 1);
                    ix   = (rem != 0);
                    up   = (rem > half) || (rem == half && ip[0]);
                end else begin
                    ip = 0;
                    ix = 1'b1;
                    up = 1'b0;
                end
                mag = ip + ((ROUND && up) ? 1 : 0);
            end
            if (e >= 0 && e <= 30)
                lat = ((e >= 23) ? e - 23 : 23 - e) + 2;
            if (!a[31] && mag > 64'sd2147483647) begin
                o  = 32'h7FFF_FFFF;
                ov = 1'b1;
            end else if (a[31] && mag > 64'sd2147483648) begin
                o  = 32'h8000_0000;
                ov = 1'b1;
            end else begin
                o = a[31] ? 32'(-mag) : 32'(mag);
            end
        end
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        case ($urandom_range(0, 9))
            0: ex = 8'd0;
            1: ex = 8'hFF;
            2: ex = 8'd126;
            3: ex = 8'(125 - $urandom_range(0, 3));
            4: ex = 8'(157 + $urandom_range(0, 2));
            default: ex = 8'($urandom_range(127, 157));
        endcase
        return {1'($urandom), ex, 23'($urandom)};
    endfunction

    // One operand from IDLE: accept, count edges until out_valid, then drain. Starts #1 after posedge.
    task automatic do_op(input logic [31:0] a, output logic [31:0] o, output logic ov,
                         output logic ix, output logic iz, output int lat);
        in_valid = 1'b1;
        A        = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A        = $urandom;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        o  = Out;
        ov = ovf;
        ix = inexact;
        iz = isZero;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)   begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (Out !== 32'd0)       begin miscompares++; $display("FAIL reset_out got %h want 00000000", Out); end
        checks++; if (isZero !== 1'b1)     begin miscompares++; $display("FAIL reset_iszero got %b want 1", isZero); end
        checks++; if (ovf !== 1'b0)        begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (inexact !== 1'b0)    begin miscompares++; $display("FAIL reset_inexact got %b want 0", inexact); end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] o_trunc;
        logic [31:0] o_round;
        logic        ov;
        logic        ix;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        tbl[12];
        logic [31:0] o, want;
        logic        ov, ix, iz;
        int          lat;
        tbl[0]  = '{32'h40490FDB, 32'h00000003, 32'h00000003, 1'b0, 1'b1, 24};
        tbl[1]  = '{32'hC0600000, 32'hFFFFFFFD, 32'hFFFFFFFC, 1'b0, 1'b1, 24};
        tbl[2]  = '{32'h3F000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 2};
        tbl[3]  = '{32'h3F400000, 32'h00000000, 32'h00000001, 1'b0, 1'b1, 2};
        tbl[4]  = '{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        tbl[5]  = '{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 2};
        tbl[6]  = '{32'h7FC00000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        tbl[7]  = '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0, 1'b0, 9};
        tbl[8]  = '{32'h4B7FFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 1'b0, 1'b0, 2};
        tbl[9]  = '{32'h80000001, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 2};
        tbl[10] = '{32'h3F800000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 25};
        tbl[11] = '{32'hCF000001, 32'h80000000, 32'h80000000, 1'b1, 1'b0, 2};
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].a, o, ov, ix, iz, lat);
            want = ROUND ? tbl[i].o_round : tbl[i].o_trunc;
            checks++; if (o !== want)               begin miscompares++; $display("FAIL dir_out a=%h got %h want %h", tbl[i].a, o, want); end
            checks++; if (ov !== tbl[i].ov)         begin miscompares++; $display("FAIL dir_ovf a=%h got %b want %b", tbl[i].a, ov, tbl[i].ov); end
            checks++; if (ix !== tbl[i].ix)         begin miscompares++; $display("FAIL dir_inexact a=%h got %b want %b", tbl[i].a, ix, tbl[i].ix); end
            checks++; if (iz !== (want == 32'd0))   begin miscompares++; $display("FAIL dir_iszero a=%h got %b want %b", tbl[i].a, iz, want == 32'd0); end
            checks++; if (lat !== tbl[i].lat)       begin miscompares++; $display("FAIL dir_latency a=%h got %0d want %0d", tbl[i].a, lat, tbl[i].lat); end
            checks++; if (in_ready !== 1'b1)        begin miscompares++; $display("FAIL dir_in_ready_after_done a=%h got %b want 1", tbl[i].a, in_ready); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, o, eo;
        logic        ov, ix, iz, eov, eix;
        int          lat, elat;
        for (int i = 0; i < 80; i++) begin
            a = rand_fp();
            ref_model(a, eo, eov, eix, elat);
            do_op(a, o, ov, ix, iz, lat);
            checks++; if (o !== eo)               begin miscompares++; $display("FAIL rnd_out a=%h got %h want %h", a, o, eo); end
            checks++; if (ov !== eov)             begin miscompares++; $display("FAIL rnd_ovf a=%h got %b want %b", a, ov, eov); end
            checks++; if (ix !== eix)             begin miscompares++; $display("FAIL rnd_inexact a=%h got %b want %b", a, ix, eix); end
            checks++; if (iz !== (eo == 32'd0))   begin miscompares++; $display("FAIL rnd_iszero a=%h got %b want %b", a, iz, eo == 32'd0); end
            checks++; if (lat !== elat)           begin miscompares++; $display("FAIL rnd_latency a=%h got %0d want %0d", a, lat, elat); end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        in_valid = 1'b1;
        A        = 32'h4EFFFFFF;
        @(posedge clk); #1;
        A   = 32'h3F800000;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++; if (cyc !== 9) begin miscompares++; $display("FAIL bp_latency got %0d want 9", cyc); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (Out !== 32'h7FFFFF80) begin miscompares++; $display("FAIL bp_out_stable cycle %0d got %h want 7fffff80", i, Out); end
            checks++; if (in_ready !== 1'b0)    begin miscompares++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
            checks++; if (out_valid !== 1'b1)   begin miscompares++; $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid); end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        logic        seen;
        logic [31:0] o;
        logic        ov, ix, iz;
        int          lat;
        in_valid = 1'b1;
        A        = 32'h40490FDB;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (Out !== 32'd0)      begin miscompares++; $display("FAIL rstmid_out got %h want 00000000", Out); end
        checks++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_result got %b want 0", seen); end
        do_op(32'hC0600000, o, ov, ix, iz, lat);
        checks++; if (o !== (ROUND ? 32'hFFFFFFFC : 32'hFFFFFFFD)) begin miscompares++; $display("FAIL rstmid_recover got %h", o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, eo;
        logic        eov, eix;
        int          elat, cyc;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = rand_fp();
            ref_model(a, eo, eov, eix, elat);
            A = a;
            @(posedge clk); #1;
            A   = $urandom;
            cyc = 1;
            while (!out_valid && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            checks++; if (Out !== eo)   begin miscompares++; $display("FAIL b2b_out a=%h got %h want %h", a, Out, eo); end
            checks++; if (ovf !== eov)  begin miscompares++; $display("FAIL b2b_ovf a=%h got %b want %b", a, ovf, eov); end
            checks++; if (cyc !== elat) begin miscompares++; $display("FAIL b2b_latency a=%h got %0d want %0d", a, cyc, elat); end
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++; $display("FAIL b2b_idle_after_done a=%h got in_ready=%b out_valid=%b want 1/0", a, in_ready, out_valid);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_shift();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
        $finish;
    end

endmodule
